fb_arbiter: RTL
===============

# fb_arbiter

Frame-buffer port arbiter. Shares the single-port 8-bit frame BRAM between the LCD scan-out reader and the camera/SPI pixel writer. The LCD reader has fixed priority and fixed read latency; writes are buffered in a small FIFO and fill the idle slots, which the LCD leaves at a 1-in-2 clock pixel rate or slower. The block sits between `lcd_controller`/ingest logic and the BRAM primitive.

## Interface
Parameters:
- `ADDR_W`, 15: pixel address width, one bank.
- `DATA_W`, 8: pixel data width.
- `FIFO_DEPTH`, 8: write FIFO entries; power of two, minimum 2.

Ports (`MEM_AW` = `ADDR_W`+1 with `FB_DOUBLE_BUFFER_EN`, else `ADDR_W`):
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `rd_req`  in  1  LCD read request; one read per high cycle.
- `rd_addr`  in  ADDR_W  LCD read address.
- `rd_data`  out  DATA_W  read data; equals `mem_rdata`.
- `rd_valid`  out  1  `rd_data` valid.
- `wr_valid`  in  1  writer has a pixel.
- `wr_ready`  out  1  FIFO accepts the pixel.
- `wr_addr`  in  ADDR_W  write address.
- `wr_data`  in  DATA_W  write pixel.
- `wr_frame_done`  in  1  pulse; the writer finished a frame.
- `rd_frame_start`  in  1  pulse; the LCD is at vsync.
- `mem_en`, `mem_we`  out  1  BRAM enable and write enable; registered.
- `mem_addr`  out  MEM_AW  BRAM address; registered.
- `mem_wdata`  out  DATA_W  BRAM write data; registered.
- `mem_rdata`  in  DATA_W  BRAM read data; 1-cycle latency after `mem_en`.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- Write accept: a transfer occurs when `wr_valid && wr_ready`. `{bank, wr_addr, wr_data}` is pushed into the FIFO.
- `wr_ready` = FIFO not full AND no swap pending.
- Slot arbiter state register `slot` ∈ {IDLE, RD, WR}, evaluated every cycle:
  - `rd_req` → RD. The read always wins.
  - else FIFO non-empty → WR, and the FIFO pops one entry.
  - else → IDLE.
- Registered outputs per slot:
  - RD: `mem_en`=1, `mem_we`=0, `mem_addr`={disp_bank, `rd_addr`}.
  - WR: `mem_en`=1, `mem_we`=1, `mem_addr`={entry bank, entry addr}, `mem_wdata`=entry data.
  - IDLE: `mem_en`=0, `mem_we`=0. Address and data hold their last value.
- Push and pop may occur in the same cycle. Occupancy is unchanged and full/empty are evaluated before the update.
- A write to the address currently being read is not hazarded. The read returns old or new data depending on slot order, and the display tolerates this.
- Reset mid-operation: FIFO flushed and in-flight entries discarded. `slot`=IDLE, `rd_valid` dropped immediately on `rst_n` low.

## Timing
- Reset values:
  - `mem_en`, `mem_we`, `rd_valid` = 0.
  - `mem_addr`, `mem_wdata` = 0.
  - `wr_ready` = 1 (0 while `rst_n` low).
  - `fifo_level` = 0.
  - `disp_bank` = 0.
- Read latency: `rd_req` in cycle c → `mem_en` in c+1 → `rd_valid`=1 with data in c+2. Latency is fixed at 2 and never stalls.
- Write latency: accept in cycle c, with the FIFO empty and no `rd_req` in c+1 → `mem_we` in c+2.
- Sustained LCD load of `rd_req` every other cycle: writer throughput is at least 1 pixel per 2 cycles.
- Continuous `rd_req`: writes starve and `wr_ready` falls once the FIFO is full. This is a legal upstream condition and no data is lost.

## Configuration
- Macro `FB_DOUBLE_BUFFER_EN`.
- Defined: `MEM_AW`=`ADDR_W`+1 and the BRAM holds two banks.
  - Writes target bank `~disp_bank`, tagged at enqueue.
  - Swap FSM has states SHOW and PEND.
    - SHOW → PEND on `wr_frame_done`.
    - PEND → SHOW on `rd_frame_start`, toggling `disp_bank`.
  - Simultaneous `wr_frame_done` and `rd_frame_start` in SHOW: toggle that cycle and stay in SHOW.
  - While in PEND, `wr_ready`=0. Queued entries still drain into the old back bank.
- Undefined: single bank, `MEM_AW`=`ADDR_W`. Frame pulses are ignored, `disp_bank` is constant 0, and `wr_ready` depends on FIFO full only.

## Structure
- Package `fb_pkg` holds:
  - `FB_ADDR_W`=15 and `FB_DATA_W`=8 defaults.
  - `slot_t` enum {IDLE, RD, WR}.
  - `swap_t` enum {SHOW, PEND}.
  - The FIFO entry struct {bank, addr, data}.
- One sub-module, `fb_wr_fifo`: synchronous FIFO with push, pop, full, empty and level outputs, and registered pointers with a wrap bit.

## Test plan
- Reset then idle → all `mem_*`=0, `wr_ready`=1, `fifo_level`=0.
- `rd_req` with `rd_addr`=0x1234, BRAM preloaded 0x5A → `mem_addr`=0x1234 at c+1; `rd_valid` and `rd_data`=0x5A at c+2.
- `rd_req` held high for 20 cycles while 10 writes are offered → 8 accepted, `wr_ready`=0. After `rd_req` drops, 8 consecutive `mem_we` cycles in order; the remaining 2 are then accepted and written.
- `rd_req` every other cycle plus a continuous writer → writes land in the gaps; `rd_valid` is never late; writer throughput is 1 per 2 cycles.
- `FB_DOUBLE_BUFFER_EN`, `wr_frame_done` at cycle 100 and `rd_frame_start` at cycle 300:
  - `wr_ready`=0 over cycles 101–300.
  - Reads switch to bank 1 after cycle 300.
  - Subsequent writes go to bank 0.
- Assert `rst_n` low with 5 entries queued → FIFO empty, no further `mem_we`, `fifo_level`=0 after release.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared types and defaults for the frame-buffer arbiter.
// FB_DOUBLE_BUFFER_EN adds a second BRAM bank (one extra address bit).
package fb_pkg;

  localparam int FB_ADDR_W = 15;
  localparam int FB_DATA_W = 8;

`ifdef FB_DOUBLE_BUFFER_EN
  localparam int FB_BANK_BITS = 1;
`else
  localparam int FB_BANK_BITS = 0;
`endif

  typedef enum logic [1:0] {IDLE, RD, WR} slot_t;
  typedef enum logic {SHOW, PEND} swap_t;

  // Write FIFO entry; bank is the back bank captured when the pixel was accepted.
  typedef struct packed {
    logic                 bank;
    logic [FB_ADDR_W-1:0] addr;
    logic [FB_DATA_W-1:0] data;
  } fb_entry_t;

endpackage

// File: rtl/fb_wr_fifo.sv
// Synchronous write FIFO for the frame-buffer arbiter.
// Pointers carry a wrap bit so full/empty need no separate counter.
module fb_wr_fifo
  import fb_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int PW    = $clog2(DEPTH),
  localparam int LW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  fb_entry_t     din,
  input  logic          pop,
  output fb_entry_t     dout,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  fb_entry_t   mem [DEPTH];
  logic [PW:0] wptr, rptr;
  logic        do_push, do_pop;

  assign full    = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);
  assign empty   = (wptr == rptr);
  assign level   = wptr - rptr;
  assign dout    = mem[rptr[PW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // Storage needs no reset: the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[PW-1:0]] <= din;
  end

endmodule

// File: rtl/fb_arbiter.sv
// Frame-buffer port arbiter: LCD reads have fixed priority and fixed 2-cycle
// latency; writer pixels queue in a FIFO and fill idle slots. FB_DOUBLE_BUFFER_EN
// enables two banks with a vsync-aligned swap.
module fb_arbiter
  import fb_pkg::*;
#(
  parameter  int ADDR_W     = FB_ADDR_W,
  parameter  int DATA_W     = FB_DATA_W,
  parameter  int FIFO_DEPTH = 8,
  localparam int MEM_AW     = ADDR_W + FB_BANK_BITS,
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_frame_done,
  input  logic              rd_frame_start,
  output logic              mem_en,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [LVL_W-1:0]  fifo_level
);

  logic        full, empty, push, pop, swap_pend;
  fb_entry_t   ent_in, ent_out;
  slot_t       slot, slot_nxt;
  logic [MEM_AW-1:0] rd_maddr, wr_maddr;

  // ---------------- bank selection / swap ----------------
`ifdef FB_DOUBLE_BUFFER_EN
  swap_t swap, swap_nxt;
  logic  disp_bank, toggle;

  always_comb begin
    swap_nxt = swap;
    toggle   = 1'b0;
    case (swap)
      SHOW: begin
        if (wr_frame_done && rd_frame_start) toggle   = 1'b1;
        else if (wr_frame_done)              swap_nxt = PEND;
      end
      PEND: begin
        if (rd_frame_start) begin
          toggle   = 1'b1;
          swap_nxt = SHOW;
        end
      end
      default: swap_nxt = SHOW;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      swap      <= SHOW;
      disp_bank <= 1'b0;
    end else begin
      swap <= swap_nxt;
      if (toggle) disp_bank <= ~disp_bank;
    end
  end

  assign swap_pend = (swap == PEND);
  assign rd_maddr  = {disp_bank, rd_addr};
  assign wr_maddr  = {ent_out.bank, ent_out.addr};
  always_comb begin
    ent_in      = '0;
    ent_in.bank = ~disp_bank;
    ent_in.addr = wr_addr;
    ent_in.data = wr_data;
  end
`else
  logic unused_ok;

  assign swap_pend = 1'b0;
  assign rd_maddr  = rd_addr;
  assign wr_maddr  = ent_out.addr;
  assign unused_ok = ^{wr_frame_done, rd_frame_start, ent_out.bank};
  always_comb begin
    ent_in      = '0;
    ent_in.addr = wr_addr;
    ent_in.data = wr_data;
  end
`endif

  // ---------------- write FIFO ----------------
  // wr_ready is forced low while reset is asserted so no pixel is lost into a flushing FIFO.
  assign wr_ready = rst_n && !full && !swap_pend;
  assign push     = wr_valid && wr_ready;
  assign pop      = !rd_req && !empty;

  fb_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (ent_in),
    .pop   (pop),
    .dout  (ent_out),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  // ---------------- slot arbiter ----------------
  always_comb begin
    slot_nxt = IDLE;
    if (rd_req)      slot_nxt = RD;
    else if (!empty) slot_nxt = WR;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot      <= IDLE;
      rd_valid  <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      slot     <= slot_nxt;
      rd_valid <= (slot == RD);
      mem_en   <= (slot_nxt != IDLE);
      mem_we   <= (slot_nxt == WR);
      case (slot_nxt)
        RD: mem_addr <= rd_maddr;
        WR: begin
          mem_addr  <= wr_maddr;
          mem_wdata <= ent_out.data;
        end
        default: ;
      endcase
    end
  end

  assign rd_data = mem_rdata;

endmodule
